// File: rtl/logo_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : logo_cmd_assembler
//  Purpose  : Parses typed LOGO lines, one ASCII keystroke at a time, and
//             turns each completed line into a 32-bit command word.
//             A line is a two-letter mnemonic (case-insensitive) with an
//             optional space-separated decimal argument, ended by Enter.
//             A backspace key discards the line typed so far.
//  Ports    : clock          - system clock
//             reset          - synchronous, active-high reset
//             key_valid      - one-cycle strobe qualifying key_ascii
//             key_ascii[7:0] - ASCII code of the pressed key
//             command_ready  - one-cycle strobe, command holds a new word
//             command[31:0]  - {opcode[3:0], 12'h000, argument[15:0]}
//             cmd_error      - one-cycle strobe, Enter on a malformed line
//             debug_state    - current parser state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module logo_cmd_assembler #(
   parameter int         MAX_DIGITS = 5,
   parameter logic [7:0] ENTER_CODE = 8'h0D,
   parameter logic [7:0] BKSP_CODE  = 8'h08
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [7:0]  key_ascii,
   output logic        command_ready,
   output logic [31:0] command,
   output logic        cmd_error,
   output logic [2:0]  debug_state
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      S_OP1  = 3'd0,
      S_OP2  = 3'd1,
      S_SEP  = 3'd2,
      S_ARG  = 3'd3,
      S_TAIL = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         first_q, first_d;      // first mnemonic letter, upper case
   logic [3:0]         op_q, op_d;            // decoded opcode of the pair
   logic [15:0]        acc_q, acc_d;          // argument accumulator
   logic [CNT_W-1:0]   cnt_q, cnt_d;          // digits accepted so far
   logic               seen_space_q, seen_space_d;
   logic [31:0]        command_q, command_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;

   // ---------------------------------------------------------------------
   // Keystroke classification
   // ---------------------------------------------------------------------
   logic        w_is_lower;
   logic [7:0]  w_upper;
   logic        w_is_letter;
   logic        w_is_digit;
   logic        w_is_space;
   logic        w_is_enter;
   logic        w_is_bksp;
   logic [3:0]  w_digit;
   logic [3:0]  w_pair_op;
   logic        w_takes_arg;
   logic [19:0] w_acc_x10;
   logic [19:0] w_next_acc;

   assign w_is_lower  = (key_ascii >= 8'h61) && (key_ascii <= 8'h7A);
   assign w_upper     = w_is_lower ? (key_ascii - 8'd32) : key_ascii;
   assign w_is_letter = (w_upper >= 8'h41) && (w_upper <= 8'h5A);
   assign w_is_digit  = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
   assign w_is_space  = (key_ascii == 8'h20);
   assign w_is_enter  = (key_ascii == ENTER_CODE);
   assign w_is_bksp   = (key_ascii == BKSP_CODE);
   // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
   assign w_digit     = key_ascii[3:0];

   // Opcodes 1..4 need an argument, 5..7 forbid one, 0 marks an unknown pair.
   always_comb begin
      w_pair_op = 4'd0;
      case ({first_q, w_upper})
         "FD":    w_pair_op = 4'd1;
         "BK":    w_pair_op = 4'd2;
         "LT":    w_pair_op = 4'd3;
         "RT":    w_pair_op = 4'd4;
         "PU":    w_pair_op = 4'd5;
         "PD":    w_pair_op = 4'd6;
         "CS":    w_pair_op = 4'd7;
         default: w_pair_op = 4'd0;
      endcase
   end

   assign w_takes_arg = (op_q != 4'd0) && (op_q <= 4'd4);

   // acc*10 as (acc<<3)+(acc<<1); 20 bits hold 65535*10+9 without wrap,
   // so the range check below sees the true value.
   assign w_acc_x10  = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1);
   assign w_next_acc = w_acc_x10 + {16'd0, w_digit};

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      first_d      = first_q;
      op_d         = op_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      seen_space_d = seen_space_q;
      command_d    = command_q;
      ready_d      = 1'b0;
      err_d        = 1'b0;

      if (key_valid) begin
         if (w_is_bksp) begin
            state_d = S_OP1;
         end else begin
            case (state_q)
               S_OP1: begin
                  if (w_is_letter) begin
                     first_d = w_upper;
                     state_d = S_OP2;
                  end else if (!w_is_space && !w_is_enter) begin
                     state_d = S_ERR;
                  end
               end
               S_OP2: begin
                  if (w_is_letter) begin
                     op_d    = w_pair_op;
                     state_d = (w_pair_op != 4'd0) ? S_SEP : S_ERR;
                  end else if (w_is_enter) begin
                     err_d   = 1'b1;
                     state_d = S_OP1;
                  end else begin
                     state_d = S_ERR;
                  end
               end
               S_SEP: begin
                  if (w_is_space) begin
                     seen_space_d = 1'b1;
                  end else if (w_is_digit) begin
                     if (w_takes_arg && seen_space_q) begin
                        acc_d   = {12'd0, w_digit};
                        cnt_d   = CNT_W'(1);
                        state_d = S_ARG;
                     end else begin
                        state_d = S_ERR;
                     end
                  end else if (w_is_enter) begin
                     if (w_takes_arg) begin
                        err_d = 1'b1;
                     end else begin
                        ready_d   = 1'b1;
                        command_d = {op_q, 28'd0};
                     end
                     state_d = S_OP1;
                  end else begin
                     state_d = S_ERR;
                  end
               end
               S_ARG: begin
                  if (w_is_digit) begin
                     if ((cnt_q == CNT_W'(MAX_DIGITS)) || (w_next_acc > 20'd65535)) begin
                        state_d = S_ERR;
                     end else begin
                        acc_d = w_next_acc[15:0];
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end else if (w_is_space) begin
                     state_d = S_TAIL;
                  end else if (w_is_enter) begin
                     ready_d   = 1'b1;
                     command_d = {op_q, 12'd0, acc_q};
                     state_d   = S_OP1;
                  end else begin
                     state_d = S_ERR;
                  end
               end
               S_TAIL: begin
                  if (w_is_enter) begin
                     ready_d   = 1'b1;
                     command_d = {op_q, 12'd0, acc_q};
                     state_d   = S_OP1;
                  end else if (!w_is_space) begin
                     state_d = S_ERR;
                  end
               end
               S_ERR: begin
                  if (w_is_enter) begin
                     err_d   = 1'b1;
                     state_d = S_OP1;
                  end
               end
               default: begin
                  state_d = S_OP1;
               end
            endcase
         end

         // Every return to the idle state starts the next line clean.
         if (state_d == S_OP1) begin
            acc_d        = 16'd0;
            cnt_d        = '0;
            seen_space_d = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_OP1;
         first_q      <= 8'd0;
         op_q         <= 4'd0;
         acc_q        <= 16'd0;
         cnt_q        <= '0;
         seen_space_q <= 1'b0;
         command_q    <= 32'd0;
         ready_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         first_q      <= first_d;
         op_q         <= op_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         seen_space_q <= seen_space_d;
         command_q    <= command_d;
         ready_q      <= ready_d;
         err_q        <= err_d;
      end
   end

   assign command_ready = ready_q;
   assign command       = command_q;
   assign cmd_error     = err_q;
   assign debug_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_logo_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logo_cmd_assembler
//  Purpose  : Self-checking bench for logo_cmd_assembler. A line-level
//             reference model buffers keystrokes and judges each finished
//             line as a whole; outputs are compared on every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logo_cmd_assembler;

   localparam logic [7:0] c_enter = 8'h0D;
   localparam logic [7:0] c_bksp  = 8'h08;

   logic        clock = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [7:0]  key_ascii;
   logic        command_ready;
   logic [31:0] command;
   logic        cmd_error;
   logic [2:0]  debug_state;

   logo_cmd_assembler #(
      .MAX_DIGITS (5),
      .ENTER_CODE (8'h0D),
      .BKSP_CODE  (8'h08)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .key_valid     (key_valid),
      .key_ascii     (key_ascii),
      .command_ready (command_ready),
      .command       (command),
      .cmd_error     (cmd_error),
      .debug_state   (debug_state)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   byte         line_q[$];
   logic [31:0] exp_cmd;
   logic        exp_ready;
   logic        exp_err;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_sp(input byte c);
      return c == 8'h20;
   endfunction

   function automatic byte to_upper(input byte c);
      return (c >= "a" && c <= "z") ? byte'(c - 8'd32) : c;
   endfunction

   // Judges a whole line: kind 0 = empty (no strobe), 1 = command, 2 = error.
   function automatic void eval_line(input byte q[$], output int kind, output logic [31:0] cmd);
      int     i = 0;
      int     n = q.size();
      int     op;
      int     sp;
      int     nd;
      longint val;
      byte    a;
      byte    b;
      cmd  = 32'd0;
      kind = 2;
      while (i < n && is_sp(q[i])) i++;
      if (i == n) begin kind = 0; return; end
      if (i + 1 >= n) return;
      a = to_upper(q[i]);
      b = to_upper(q[i+1]);
      i += 2;
      op = 0;
      if      (a == "F" && b == "D") op = 1;
      else if (a == "B" && b == "K") op = 2;
      else if (a == "L" && b == "T") op = 3;
      else if (a == "R" && b == "T") op = 4;
      else if (a == "P" && b == "U") op = 5;
      else if (a == "P" && b == "D") op = 6;
      else if (a == "C" && b == "S") op = 7;
      if (op == 0) return;
      if (op >= 5) begin
         while (i < n && is_sp(q[i])) i++;
         if (i != n) return;
         kind = 1;
         cmd  = 32'(op) << 28;
         return;
      end
      sp = 0;
      while (i < n && is_sp(q[i])) begin sp++; i++; end
      if (sp == 0) return;
      nd  = 0;
      val = 0;
      while (i < n && q[i] >= "0" && q[i] <= "9") begin
         if (nd < 10) val = val * 10 + longint'(q[i] - 8'h30);
         nd++;
         i++;
      end
      if (nd == 0 || nd > 5 || val > 65535) return;
      while (i < n && is_sp(q[i])) i++;
      if (i != n) return;
      kind = 1;
      cmd  = (32'(op) << 28) | 32'(val);
   endfunction

   // Called at a falling edge: check what the last rising edge produced,
   // then drive this cycle's inputs and predict the next rising edge.
   task automatic step(input bit rst, input bit kv, input byte c);
      int          kind;
      logic [31:0] cmd;
      check_value("command_ready", 32'(command_ready), 32'(exp_ready));
      check_value("cmd_error",     32'(cmd_error),     32'(exp_err));
      check_value("command",       command,            exp_cmd);
      reset     = rst;
      key_valid = kv;
      key_ascii = c;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      if (rst) begin
         line_q.delete();
         exp_cmd = 32'd0;
      end else if (kv) begin
         if (c == c_bksp) begin
            line_q.delete();
         end else if (c == c_enter) begin
            eval_line(line_q, kind, cmd);
            if (kind == 1) begin
               exp_ready = 1'b1;
               exp_cmd   = cmd;
            end else if (kind == 2) begin
               exp_err = 1'b1;
            end
            line_q.delete();
         end else begin
            line_q.push_back(c);
         end
      end
      @(negedge clock);
   endtask

   task automatic type_str(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
   endtask

   task automatic type_line(input string s);
      type_str(s);
      step(1'b0, 1'b1, c_enter);
   endtask

   // Builds a random, mostly plausible line and types it with random gaps.
   task automatic random_line();
      string mn[9] = '{"FD", "BK", "LT", "RT", "PU", "PD", "CS", "XY", "FQ"};
      string junk  = "#A9 z.";
      byte   kq[$];
      string m;
      int    nd;
      m = mn[$urandom_range(0, 8)];
      repeat ($urandom_range(0, 2)) kq.push_back(8'h20);
      for (int i = 0; i < 2; i++) begin
         byte ch;
         ch = m[i];
         if ($urandom_range(0, 1) == 1) ch = byte'(ch + 8'd32);
         kq.push_back(ch);
      end
      repeat ($urandom_range(0, 2)) kq.push_back(8'h20);
      nd = $urandom_range(0, 6);
      for (int i = 0; i < nd; i++) kq.push_back(byte'(8'h30 + $urandom_range(0, 9)));
      repeat ($urandom_range(0, 2)) kq.push_back(8'h20);
      if ($urandom_range(0, 9) == 0) kq[$urandom_range(0, kq.size() - 1)] = junk[$urandom_range(0, junk.len() - 1)];
      if ($urandom_range(0, 9) == 0) kq.insert($urandom_range(0, kq.size() - 1), c_bksp);
      foreach (kq[i]) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, byte'($urandom_range(0, 255)));
         if ($urandom_range(0, 39) == 0) step(1'b1, 1'b0, 8'h00);
         step(1'b0, 1'b1, kq[i]);
      end
      step(1'b0, 1'b1, c_enter);
   endtask

   initial begin
      reset     = 1'b1;
      key_valid = 1'b0;
      key_ascii = 8'h00;
      exp_cmd   = 32'd0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      repeat (2) @(negedge clock);
      check_value("reset_state", 32'(debug_state), 32'd0);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      type_line("FD 100");
      check_value("fd100", command, 32'h1000_0064);
      type_line("  rt 90  ");
      check_value("rt90", command, 32'h4000_005A);
      type_line("PU");
      check_value("pu", command, 32'h5000_0000);
      type_line("cs");
      check_value("cs", command, 32'h7000_0000);

      type_line("FD");
      type_line("FD100");
      type_line("PD 5");
      type_line("XY 3");
      type_line("FD 65536");
      type_line("FD 123456");
      check_value("err_hold", command, 32'h7000_0000);

      type_line("BK 65535");
      check_value("bk65535", command, 32'h2000_FFFF);
      type_str("LT 12");
      step(1'b0, 1'b1, c_bksp);
      type_line("FD 7");
      check_value("bksp_fd7", command, 32'h1000_0007);
      step(1'b0, 1'b1, c_enter);
      step(1'b0, 1'b0, 8'h00);

      type_str("FD 4");
      step(1'b1, 1'b0, 8'h00);
      check_value("reset_cmd", command, 32'd0);
      check_value("reset_state2", 32'(debug_state), 32'd0);
      type_line("LT 1");
      check_value("lt1", command, 32'h3000_0001);

      for (int n = 0; n < 200; n++) random_line();
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
